tmds_decoder: RTL and testbench

TMDS receive-side decoder for one HDMI channel; the inverse of our TMDS encoder. Takes raw 10-bit words from the channel deserializer at pixel clock, finds the symbol boundary from control tokens, and locks to it. Then decodes each 10-bit symbol back to 8-bit data, or to the 2-bit control value, plus a data-enable flag. One instance per channel, between the deserializer and the sink video timing logic.

---
 rtl/tmds_pkg.sv | 36 +++
 rtl/tmds_decoder_if.sv | 17 +
 rtl/tmds_word_align.sv | 28 ++
 rtl/tmds_decoder.sv | 148 ++++++++++++++
 tb/tb_tmds_decoder.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tmds_pkg.sv
`default_nettype none
// =====================================================================
// tmds_pkg : TMDS control tokens, decoder FSM states and helpers.  Rev 1.0
// =====================================================================
package tmds_pkg;

   localparam logic [9:0] TOKEN_00 = 10'b1101010100;
   localparam logic [9:0] TOKEN_01 = 10'b0010101011;
   localparam logic [9:0] TOKEN_10 = 10'b0101010100;
   localparam logic [9:0] TOKEN_11 = 10'b1010101011;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      SLIP   = 2'd1,
      LOCKED = 2'd2
   } dec_state_t;

   function automatic logic [9:0] ctrl_to_token(input logic [1:0] c);
      case (c)
         2'b00:   return TOKEN_00;
         2'b01:   return TOKEN_01;
         2'b10:   return TOKEN_10;
         default: return TOKEN_11;
      endcase
   endfunction

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++)
         n = n + {3'b000, v[i]};
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_decoder_if.sv
`default_nettype none
// =====================================================================
// tmds_decoder_if : deserializer word in, decoded symbol out.  Rev 1.0
// =====================================================================
interface tmds_decoder_if;
   logic [9:0] din;
   logic [7:0] dout;
   logic [1:0] ctrl;
   logic       de;
   logic       locked;
   logic [3:0] offset;
   logic       err;

   modport master (output din, input dout, ctrl, de, locked, offset, err);
   modport slave  (input din, output dout, ctrl, de, locked, offset, err);
endinterface
`default_nettype wire

// File: rtl/tmds_word_align.sv
`default_nettype none
// =====================================================================
// tmds_word_align : extracts a 10-bit symbol at a bit offset from two words.  Rev 1.0
// =====================================================================
module tmds_word_align (
   input  logic       clk,
   input  logic       Reset,
   input  logic [9:0] din,
   input  logic [3:0] offset,
   output logic [9:0] w
);
   logic [9:0]  din_prev;
   logic [19:0] window;

   // Earlier word sits in the low half, so bit 0 of the window is earliest on the wire.
   assign window = {din, din_prev};

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         din_prev <= '0;
         w        <= '0;
      end else begin
         din_prev <= din;
         w        <= 10'(window >> offset);
      end
   end
endmodule
`default_nettype wire

// File: rtl/tmds_decoder.sv
`default_nettype none
// =====================================================================
// tmds_decoder : TMDS channel decoder with token-based symbol lock.
// Define TMDS_DEC_ERR_EN to add the data encoding-rule check.  Rev 1.0
// =====================================================================
module tmds_decoder
   import tmds_pkg::*;
#(
   parameter int SEARCH_WIN  = 4096,
   parameter int LOCK_TOKENS = 8
) (
   input  logic           clk,
   input  logic           Reset,
   tmds_decoder_if.slave  bus
);
   localparam int            CW       = $clog2(SEARCH_WIN + 1);
   localparam logic [CW-1:0] WIN_MAX  = CW'(SEARCH_WIN);
   localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_TOKENS);

   dec_state_t    state, state_next;
   logic [CW-1:0] tok_run, win_cnt;
   logic [3:0]    offset;
   logic [9:0]    w;
   logic [7:0]    d, dec;
   logic          is_tok;
   logic [1:0]    tok_ctrl;
   logic          err_hit;
   logic [7:0]    dout;
   logic [1:0]    ctrl;
   logic          de, err;

   tmds_word_align u_align (
      .clk    (clk),
      .Reset  (Reset),
      .din    (bus.din),
      .offset (offset),
      .w      (w)
   );

   always_comb begin
      is_tok   = 1'b0;
      tok_ctrl = 2'b00;
      for (int c = 0; c < 4; c++) begin
         if (w == ctrl_to_token(2'(c))) begin
            is_tok   = 1'b1;
            tok_ctrl = 2'(c);
         end
      end
   end

   always_comb begin
      d      = w[9] ? ~w[7:0] : w[7:0];
      dec    = '0;
      dec[0] = d[0];
      for (int i = 1; i < 8; i++)
         dec[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) state <= SEARCH;
      else       state <= state_next;
   end

   // Lock takes priority over an expiring search window.
   always_comb begin
      state_next = state;
      case (state)
         SEARCH: begin
            if (tok_run >= LOCK_MAX)     state_next = LOCKED;
            else if (win_cnt >= WIN_MAX) state_next = SLIP;
         end
         SLIP:   state_next = SEARCH;
         LOCKED: begin
            if (win_cnt >= WIN_MAX) state_next = SLIP;
         end
         default: state_next = SEARCH;
      endcase
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         tok_run <= '0;
         win_cnt <= '0;
         offset  <= 4'd0;
      end else if (state == SLIP) begin
         tok_run <= '0;
         win_cnt <= '0;
         offset  <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
      end else if (is_tok) begin
         win_cnt <= '0;
         if (tok_run != '1) tok_run <= tok_run + 1'b1;
      end else begin
         tok_run <= '0;
         if (win_cnt != '1) win_cnt <= win_cnt + 1'b1;
      end
   end

`ifdef TMDS_DEC_ERR_EN
   logic [3:0]  ones;
   logic        exp_w8;
   logic [15:0] err_cnt;

   // Re-run the encoder's XOR/XNOR choice on the decoded byte and compare with the sent flag.
   assign ones    = popcount8(dec);
   assign exp_w8  = ~((ones > 4'd4) || (ones == 4'd4 && !dec[0]));
   assign err_hit = (state == LOCKED) && !is_tok && (exp_w8 != w[8]);

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset)                          err_cnt <= '0;
      else if (state == SLIP)             err_cnt <= '0;
      else if (err_hit && err_cnt != '1)  err_cnt <= err_cnt + 16'd1;
   end
`else
   assign err_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         dout <= '0;
         ctrl <= '0;
         de   <= 1'b0;
         err  <= 1'b0;
      end else if (state == LOCKED) begin
         err <= err_hit;
         if (is_tok) begin
            de   <= 1'b0;
            dout <= '0;
            ctrl <= tok_ctrl;
         end else begin
            de   <= 1'b1;
            dout <= dec;
         end
      end else begin
         dout <= '0;
         ctrl <= '0;
         de   <= 1'b0;
         err  <= 1'b0;
      end
   end

   assign bus.dout   = dout;
   assign bus.ctrl   = ctrl;
   assign bus.de     = de;
   assign bus.err    = err;
   assign bus.locked = (state == LOCKED);
   assign bus.offset = offset;
endmodule
`default_nettype wire

// File: tb/tb_tmds_decoder.sv
`default_nettype none
// =====================================================================
// tb_tmds_decoder : scoreboard bench for tmds_decoder (SEARCH_WIN=64).  Rev 1.0
// =====================================================================
module tb_tmds_decoder;
   logic clk   = 1'b0;
   logic Reset = 1'b1;

   tmds_decoder_if bus();

   tmds_decoder #(.SEARCH_WIN(64), .LOCK_TOKENS(8)) dut (
      .clk   (clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

`ifdef TMDS_DEC_ERR_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   logic [9:0] tok_tab [4] = '{10'b1101010100, 10'b0010101011,
                               10'b0101010100, 10'b1010101011};

   int          n_checks = 0;
   int          n_fail   = 0;
   int          enc_cnt  = 0;
   logic [19:0] pend     = '0;
   int          pend_n   = 0;
   logic [8:0]  exp_q [$];
   logic [1:0]  ctrl_q [$];
   logic [1:0]  last_push = 2'b00;
   logic [1:0]  last_seen = 2'b00;
   bit          mon_en    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int ones8(input logic [7:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 8; i++) n += int'(v[i]);
      return n;
   endfunction

   // Reference DVI encoder with running disparity.
   task automatic encode(input logic [7:0] dd, output logic [9:0] q);
      logic [8:0] qm;
      int n1, n1q, n0q;
      n1    = ones8(dd);
      qm[0] = dd[0];
      if (n1 > 4 || (n1 == 4 && dd[0] == 1'b0)) begin
         for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ dd[i]);
         qm[8] = 1'b0;
      end else begin
         for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ dd[i];
         qm[8] = 1'b1;
      end
      n1q = ones8(qm[7:0]);
      n0q = 8 - n1q;
      if (enc_cnt == 0 || n1q == n0q) begin
         q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
         enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
      end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
         q = {1'b1, qm[8], ~qm[7:0]};
         enc_cnt += (qm[8] ? 2 : 0) + n0q - n1q;
      end else begin
         q = {1'b0, qm[8], qm[7:0]};
         enc_cnt += n1q - n0q - (qm[8] ? 0 : 2);
      end
   endtask

   // Serialise symbols onto the wire with pend_n leading bits of skew.
   task automatic send_word(input logic [9:0] sym);
      logic [19:0] tmp;
      tmp = pend | (20'(sym) << pend_n);
      @(posedge clk);
      #1;
      bus.din = tmp[9:0];
      pend    = tmp >> 10;
   endtask

   task automatic send_tok(input logic [1:0] c);
      enc_cnt = 0;
      if (c != last_push) begin
         ctrl_q.push_back(c);
         last_push = c;
      end
      send_word(tok_tab[c]);
   endtask

   task automatic send_data(input logic [7:0] b, input bit push);
      logic [9:0] q;
      encode(b, q);
      if (push) exp_q.push_back({1'b0, b});
      send_word(q);
   endtask

   task automatic send_raw(input logic [9:0] sym, input logic [7:0] exp_d, input logic exp_e);
      exp_q.push_back({exp_e, exp_d});
      send_word(sym);
   endtask

   task automatic send_frame(input int lo, input int hi);
      for (int b = lo; b <= hi; b++) begin
         if ((b % 32) == 0) repeat (4) send_tok(2'b00);
         send_data(8'(b), 1'b1);
      end
   endtask

   // Feed ctrl=00 tokens until lock, checking each offset step on the way.
   task automatic relock(input int start_off, input bit chk_iv,
                         output int steps, output int wraps, output bit got);
      int prev, last_i;
      prev   = start_off;
      last_i = 0;
      steps  = 0;
      wraps  = 0;
      got    = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
         send_tok(2'b00);
         if (int'(bus.offset) != prev) begin
            check("offset_step", 32'(bus.offset), 32'((prev + 1) % 10));
            if (chk_iv && steps > 0)
               check("slip_interval_64_70", 32'((i - last_i) >= 64 && (i - last_i) <= 70), 32'd1);
            if (prev == 9 && bus.offset == 4'd0) wraps++;
            steps++;
            prev   = int'(bus.offset);
            last_i = i;
         end
         if (bus.locked) got = 1'b1;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && !Reset) begin
         if (bus.locked && bus.de) begin
            if (exp_q.size() == 0) begin
               check("unexpected_data", 32'(bus.dout), 32'hFFFF_FFFF);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               check("data_dout", 32'(bus.dout), 32'(e[7:0]));
               check("data_err", 32'(bus.err), 32'(e[8]));
            end
         end else if (bus.locked) begin
            check("ctrl_dout_zero", 32'(bus.dout), 32'd0);
            if (bus.ctrl != last_seen) begin
               if (ctrl_q.size() == 0) begin
                  check("unexpected_ctrl", 32'(bus.ctrl), 32'hFFFF_FFFF);
               end else begin
                  logic [1:0] c;
                  c = ctrl_q.pop_front();
                  check("ctrl_value", 32'(bus.ctrl), 32'(c));
               end
               last_seen = bus.ctrl;
            end
         end else begin
            check("unlocked_idle", 32'({bus.de, bus.ctrl, bus.dout, bus.err}), 32'd0);
         end
      end
   end

   initial begin
      int  lock_at, steps, wraps;
      bit  got;
      bus.din = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 32'({bus.dout, bus.ctrl, bus.de, bus.locked, bus.offset, bus.err}), 32'd0);
      Reset  = 1'b0;
      mon_en = 1'b1;

      // Aligned stream: lock on tokens, then data 0x00..0xFF
      lock_at = 0;
      for (int k = 1; k <= 16; k++) begin
         send_tok(2'b00);
         if (bus.locked && lock_at == 0) lock_at = k;
      end
      check("lock_after_8_tokens", 32'(lock_at >= 8 && lock_at <= 13), 32'd1);
      check("offset_aligned", 32'(bus.offset), 32'd0);
      send_frame(0, 255);

      // Control token runs while locked
      repeat (8) send_tok(2'b11);
      repeat (8) send_tok(2'b01);
      repeat (4) send_tok(2'b00);

      // Raw symbols: 0x00 with bit 8 flipped, and an XOR-flagged symbol decoding to 0xFF
      send_raw(10'h000, 8'hFE, 1'b0);
      send_raw(10'h155, 8'hFF, ERR_EXP);
      repeat (6) send_tok(2'b00);
      check("drain_1", 32'(exp_q.size() + ctrl_q.size()), 32'd0);
`ifdef TMDS_DEC_ERR_EN
      check("err_cnt", 32'(dut.err_cnt), 32'd1);
`endif

      // Asynchronous reset mid-stream
      check("locked_before_reset", 32'(bus.locked), 32'd1);
      mon_en = 1'b0;
      send_data(8'h5A, 1'b0);
      @(posedge clk);
      #3;
      Reset = 1'b1;
      #1;
      check("async_rst_dout", 32'(bus.dout), 32'd0);
      check("async_rst_ctrl", 32'(bus.ctrl), 32'd0);
      check("async_rst_de", 32'(bus.de), 32'd0);
      check("async_rst_locked", 32'(bus.locked), 32'd0);
      check("async_rst_offset", 32'(bus.offset), 32'd0);
      check("async_rst_err", 32'(bus.err), 32'd0);
      exp_q.delete();
      ctrl_q.delete();
      last_push = 2'b00;
      last_seen = 2'b00;
      @(posedge clk);
      #1;
      Reset   = 1'b0;
      pend    = '0;
      pend_n  = 3;
      enc_cnt = 0;
      mon_en  = 1'b1;

      // Stream skewed by 3 bits: walk 0->1->2->3 and lock
      relock(0, 1'b1, steps, wraps, got);
      check("skew_locked", 32'(got), 32'd1);
      check("skew_offset", 32'(bus.offset), 32'd3);
      check("skew_steps", 32'(steps), 32'd3);
      repeat (2) send_tok(2'b00);
      send_frame(64, 127);
      repeat (6) send_tok(2'b00);
      check("drain_2", 32'(exp_q.size() + ctrl_q.size()), 32'd0);

      // Data-only run loses lock, then search wraps 9->0 back to offset 3
      mon_en = 1'b0;
      for (int i = 0; i < 75; i++) send_data(8'(8'h10 + i), 1'b0);
      check("lock_lost", 32'(bus.locked), 32'd0);
      check("offset_after_loss", 32'(bus.offset), 32'd4);
      mon_en = 1'b1;
      relock(4, 1'b0, steps, wraps, got);
      check("relock_locked", 32'(got), 32'd1);
      check("relock_offset", 32'(bus.offset), 32'd3);
      check("relock_steps", 32'(steps), 32'd9);
      check("relock_wrap_9_to_0", 32'(wraps), 32'd1);
      repeat (2) send_tok(2'b00);
      send_frame(128, 191);
      repeat (6) send_tok(2'b00);
      check("drain_3", 32'(exp_q.size() + ctrl_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
